dbus_arbiter: RTL

- Shares the common data bus (memory port1 / device path behind the router) between two masters: m0 = CPU data port, m1 = loader/DMA master.
- Serialises requests into single-beat slave accesses, waits a fixed slave read latency, then returns a one-cycle ready with registered read data.
- Round-robin arbitration with an optional lock for back-to-back bursts. A burst limit prevents starvation.

---
 rtl/dbus_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the shared data bus (m0 = CPU data port, m1 = loader/DMA).
// Each request becomes one single-beat slave access. Reads wait a fixed slave
// latency; every transaction ends with a one-cycle ready pulse to its owner.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no transaction; arbitrate among pending requests
// ISSUE | one cycle driving the latched access onto the slave port
// WAIT  | read in flight; RD_LAT cycles, slave data captured on the last one
// RESP  | ready pulse to the owner; owner's lock sampled for the next grant
module dbus_arbiter #(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic        m0_wen,
    input  logic        m1_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic [31:0] rdata,
    output logic [31:0] s_addr,
    output logic        s_ren,
    output logic        s_wen,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_B   = 8'(MAX_BURST);
    localparam logic [2:0] WAIT_LD = 3'(RD_LAT - 1);

    state_t      state;
    state_t      state_nxt;

    // Arbitration bookkeeping
    logic        ptr;
    logic        ptr_nxt;
    logic [7:0]  burst_cnt;
    logic [7:0]  burst_cnt_nxt;
    logic        lock_q;
    logic        lock_q_nxt;
    logic        lat_wen;
    logic        lat_wen_nxt;
    logic [2:0]  wait_cnt;
    logic [2:0]  wait_cnt_nxt;

    // Next values of the registered outputs
    logic        owner_nxt;
    logic        busy_nxt;
    logic        m0_ready_nxt;
    logic        m1_ready_nxt;
    logic [31:0] rdata_nxt;
    logic [31:0] s_addr_nxt;
    logic        s_ren_nxt;
    logic        s_wen_nxt;
    logic [3:0]  s_wstrb_nxt;
    logic [31:0] s_wdata_nxt;

    // Winner selection
    logic        own_req;
    logic        oth_req;
    logic        cont;
    logic        win;
    logic [7:0]  cnt_inc;
    logic        sel_wen;
    logic [31:0] sel_addr;
    logic [3:0]  sel_wstrb;
    logic [31:0] sel_wdata;

    // Pick the winner: locked continuation first, then lone requester, then pointer
    always_comb begin
        own_req = owner ? m1_req : m0_req;
        oth_req = owner ? m0_req : m1_req;
        // Continuation is refused only when the burst limit is hit and the other side is waiting
        cont    = lock_q & own_req & ((burst_cnt < MAX_B) | ~oth_req);
        cnt_inc = burst_cnt + 8'd1;
        if (cont) begin
            win = owner;
        end else if (m0_req & m1_req) begin
            win = ptr;
        end else begin
            win = m1_req;
        end
        sel_wen   = win ? m1_wen   : m0_wen;
        sel_addr  = win ? m1_addr  : m0_addr;
        sel_wstrb = win ? m1_wstrb : m0_wstrb;
        sel_wdata = win ? m1_wdata : m0_wdata;
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        burst_cnt_nxt = burst_cnt;
        lock_q_nxt    = lock_q;
        lat_wen_nxt   = lat_wen;
        wait_cnt_nxt  = wait_cnt;
        owner_nxt     = owner;
        rdata_nxt     = rdata;
        m0_ready_nxt  = 1'b0;
        m1_ready_nxt  = 1'b0;
        s_addr_nxt    = 32'd0;
        s_ren_nxt     = 1'b0;
        s_wen_nxt     = 1'b0;
        s_wstrb_nxt   = 4'd0;
        s_wdata_nxt   = 32'd0;

        case (state)
            IDLE: begin
                if (m0_req | m1_req) begin
                    state_nxt = ISSUE;
                    owner_nxt = win;
                    if (cont) begin
                        // With nobody else waiting the count wraps instead of forcing a release
                        if (~oth_req && (cnt_inc >= MAX_B)) begin
                            burst_cnt_nxt = 8'd0;
                        end else begin
                            burst_cnt_nxt = cnt_inc;
                        end
                    end else begin
                        burst_cnt_nxt = 8'd0;
                        ptr_nxt       = ~win;
                    end
                    lat_wen_nxt = sel_wen;
                    s_addr_nxt  = sel_addr;
                    s_wstrb_nxt = sel_wstrb;
                    s_wdata_nxt = sel_wdata;
                    s_wen_nxt   = sel_wen;
                    s_ren_nxt   = ~sel_wen;
                end
            end
            ISSUE: begin
                if (lat_wen) begin
                    state_nxt    = RESP;
                    m0_ready_nxt = ~owner;
                    m1_ready_nxt = owner;
                end else begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WAIT_LD;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt    = RESP;
                    rdata_nxt    = s_rdata;
                    m0_ready_nxt = ~owner;
                    m1_ready_nxt = owner;
                end else begin
                    wait_cnt_nxt = wait_cnt - 3'd1;
                end
            end
            RESP: begin
                lock_q_nxt = owner ? m1_lock : m0_lock;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State, bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            burst_cnt <= 8'd0;
            lock_q    <= 1'b0;
            lat_wen   <= 1'b0;
            wait_cnt  <= 3'd0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            rdata     <= 32'd0;
            s_addr    <= 32'd0;
            s_ren     <= 1'b0;
            s_wen     <= 1'b0;
            s_wstrb   <= 4'd0;
            s_wdata   <= 32'd0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            lock_q    <= lock_q_nxt;
            lat_wen   <= lat_wen_nxt;
            wait_cnt  <= wait_cnt_nxt;
            owner     <= owner_nxt;
            busy      <= busy_nxt;
            m0_ready  <= m0_ready_nxt;
            m1_ready  <= m1_ready_nxt;
            rdata     <= rdata_nxt;
            s_addr    <= s_addr_nxt;
            s_ren     <= s_ren_nxt;
            s_wen     <= s_wen_nxt;
            s_wstrb   <= s_wstrb_nxt;
            s_wdata   <= s_wdata_nxt;
        end
    end

endmodule
